// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: state encoding, grant codes,
// default widths and the read data returned by an aborted (timed-out) transfer.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    localparam logic [15:0] TIMEOUT_RDATA = 16'hFFFF;

endpackage

// File: rtl/mem_timeout_ctr.sv
// ACCESS-phase wait counter: cleared outside ACCESS, counts stalled cycles and
// flags the cycle on which the wait limit is reached. Used only with MEM_TIMEOUT_EN.
module mem_timeout_ctr
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Hit on the last permitted cycle so the abort lands after exactly LIMIT stalls.
    assign hit_c = (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access
// (data wins). Optional ACCESS timeout abort is enabled by defining MEM_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              bus_err
);

    state_e            state, state_nx;
    logic              mem_req_nx, mem_we_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_nx;
    logic [DATA_W-1:0] if_rdata_nx, d_rdata_nx;
    logic              if_ack_nx, d_ack_nx;
    logic [1:0]        grant_nx;
    logic              busy_nx, bus_err_nx;
    logic              timeout_c;
    logic [DATA_W-1:0] rd_c;

`ifdef MEM_TIMEOUT_EN
    mem_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (state != ST_ACCESS),
        .en    ((state == ST_ACCESS) && !mem_ack),
        .hit_c (timeout_c)
    );
`else
    // Without the counter ACCESS waits forever; the limit only matters with it.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYC;
    assign timeout_c = 1'b0;
`endif

    // A real completion beats a simultaneous timeout.
    assign rd_c = mem_ack ? mem_rdata : DATA_W'(TIMEOUT_RDATA);

    // Next-state and next-output logic.
    always_comb begin
        state_nx     = state;
        mem_req_nx   = mem_req;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        if_rdata_nx  = if_rdata;
        d_rdata_nx   = d_rdata;
        grant_nx     = grant;
        if_ack_nx    = 1'b0;
        d_ack_nx     = 1'b0;
        bus_err_nx   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (d_req) begin
                    mem_req_nx   = 1'b1;
                    mem_we_nx    = d_we;
                    mem_addr_nx  = d_addr;
                    mem_wdata_nx = d_wdata;
                    grant_nx     = GNT_D;
                    state_nx     = ST_ACCESS;
                end else if (if_req) begin
                    mem_req_nx  = 1'b1;
                    mem_we_nx   = 1'b0;
                    mem_addr_nx = if_addr;
                    grant_nx    = GNT_IF;
                    state_nx    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ack || timeout_c) begin
                    mem_req_nx = 1'b0;
                    mem_we_nx  = 1'b0;
                    bus_err_nx = !mem_ack;
                    state_nx   = ST_DONE;
                    if (grant == GNT_IF) begin
                        if_ack_nx   = 1'b1;
                        if_rdata_nx = rd_c;
                    end else begin
                        d_ack_nx = 1'b1;
                        if (!mem_we) begin
                            d_rdata_nx = rd_c;
                        end
                    end
                end
            end
            ST_DONE: begin
                grant_nx = GNT_NONE;
                state_nx = ST_IDLE;
            end
            default: begin
                grant_nx = GNT_NONE;
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            grant     <= GNT_NONE;
            busy      <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            mem_req   <= mem_req_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            if_rdata  <= if_rdata_nx;
            d_rdata   <= d_rdata_nx;
            if_ack    <= if_ack_nx;
            d_ack     <= d_ack_nx;
            grant     <= grant_nx;
            busy      <= busy_nx;
            bus_err   <= bus_err_nx;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model and a variable-wait memory responder.
module tb_mem_bus_arbiter;

    localparam int unsigned AW     = 16;
    localparam int unsigned DW     = 16;
    localparam int unsigned TO_CYC = 8;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic [1:0]    grant;
    logic          busy, bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] dev_mem [256];
    int cur_wait = 0;   // memory wait states for the next transfer; -1 = never ack
    bit noise_en = 0;   // random mem_ack while no request is outstanding
    int acc_cnt  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .grant     (grant),
        .busy      (busy),
        .bus_err   (bus_err)
    );

    // Memory device: acks after cur_wait stalled cycles of an outstanding request.
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            mem_ack   = (cur_wait >= 0) && (acc_cnt == cur_wait);
            mem_rdata = mem_we ? DW'($urandom) : dev_mem[mem_addr[7:0]];
            if (mem_ack && mem_we) dev_mem[mem_addr[7:0]] = mem_wdata;
            acc_cnt++;
        end else begin
            acc_cnt   = 0;
            mem_ack   = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = DW'($urandom);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({mem_req, mem_we, if_ack, d_ack, busy, bus_err} !== 6'b0 || grant !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ctrl: req=%b we=%b if_ack=%b d_ack=%b busy=%b err=%b grant=%b, want all 0",
                     mem_req, mem_we, if_ack, d_ack, busy, bus_err, grant);
        end
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h d_rdata=%h, want 0",
                     mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || grant !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b req=%b grant=%b, want 0 0 00", busy, mem_req, grant);
        end
    endtask

    task automatic test_zero_wait_fetch();
        cur_wait = 0;
        dev_mem[8'h04] = 16'h1234;
        if_addr = 16'h0004;
        if_req  = 1'b1;
        tick();
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0004 || grant !== 2'b01 ||
            busy !== 1'b1 || if_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL zw_access: req=%b we=%b addr=%h grant=%b busy=%b ack=%b, want 1 0 0004 01 1 0",
                     mem_req, mem_we, mem_addr, grant, busy, if_ack);
        end
        tick();
        n_checks++;
        if (if_ack !== 1'b1 || d_ack !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b1 || if_rdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL zw_done: if_ack=%b d_ack=%b req=%b busy=%b rdata=%h, want 1 0 0 1 1234",
                     if_ack, d_ack, mem_req, busy, if_rdata);
        end
        if_req = 1'b0;
        tick();
        n_checks++;
        if (if_ack !== 1'b0 || busy !== 1'b0 || grant !== 2'b00 || if_rdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL zw_idle: if_ack=%b busy=%b grant=%b rdata=%h, want 0 0 00 1234",
                     if_ack, busy, grant, if_rdata);
        end
    endtask

    task automatic test_contention();
        cur_wait = 0;
        dev_mem[8'h08] = 16'h5A5A;
        if_addr = 16'h0008;
        d_we    = 1'b1;
        d_addr  = 16'h0010;
        d_wdata = 16'hBEEF;
        if_req  = 1'b1;
        d_req   = 1'b1;
        tick();
        n_checks++;
        if (grant !== 2'b10 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0010 ||
            mem_wdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL cont_write: grant=%b req=%b we=%b addr=%h wdata=%h, want 10 1 1 0010 beef",
                     grant, mem_req, mem_we, mem_addr, mem_wdata);
        end
        tick();
        n_checks++;
        if (d_ack !== 1'b1 || if_ack !== 1'b0 || d_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL cont_d_ack: d_ack=%b if_ack=%b d_rdata=%h, want 1 0 0000", d_ack, if_ack, d_rdata);
        end
        d_req = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || grant !== 2'b00 || if_ack !== 1'b0 || d_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_gap: busy=%b grant=%b if_ack=%b d_ack=%b, want 0 00 0 0",
                     busy, grant, if_ack, d_ack);
        end
        tick();
        n_checks++;
        if (grant !== 2'b01 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0008) begin
            n_fail++;
            $display("FAIL cont_fetch: grant=%b req=%b we=%b addr=%h, want 01 1 0 0008",
                     grant, mem_req, mem_we, mem_addr);
        end
        tick();
        n_checks++;
        if (if_ack !== 1'b1 || d_ack !== 1'b0 || if_rdata !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL cont_if_ack: if_ack=%b d_ack=%b rdata=%h, want 1 0 5a5a", if_ack, d_ack, if_rdata);
        end
        if_req = 1'b0;
        tick();
        n_checks++;
        if (dev_mem[8'h10] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL cont_mem: mem[0010]=%h, want beef", dev_mem[8'h10]);
        end
    endtask

    task automatic test_wait_states();
        cur_wait = 4;
        dev_mem[8'h20] = 16'h00AA;
        d_we   = 1'b0;
        d_addr = 16'h0020;
        d_req  = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0020 || d_ack !== 1'b0 ||
                d_rdata !== 16'h0000) begin
                n_fail++;
                $display("FAIL ws_access%0d: req=%b we=%b addr=%h ack=%b rdata=%h, want 1 0 0020 0 0000",
                         k, mem_req, mem_we, mem_addr, d_ack, d_rdata);
            end
            tick();
        end
        n_checks++;
        if (d_ack !== 1'b1 || mem_req !== 1'b0 || d_rdata !== 16'h00AA) begin
            n_fail++;
            $display("FAIL ws_done: ack=%b req=%b rdata=%h, want 1 0 00aa", d_ack, mem_req, d_rdata);
        end
        d_req = 1'b0;
        tick();
        n_checks++;
        if (d_ack !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ws_idle: ack=%b busy=%b, want 0 0", d_ack, busy);
        end
    endtask

    task automatic test_reset_mid_access();
        cur_wait = -1;
        if_addr  = 16'h0030;
        if_req   = 1'b1;
        tick();
        tick();
        n_checks++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: req=%b busy=%b, want 1 1", mem_req, busy);
        end
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || grant !== 2'b00 || busy !== 1'b0 || if_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_mid_async: req=%b grant=%b busy=%b rdata=%h, want 0 00 0 0000",
                     mem_req, grant, busy, if_rdata);
        end
        if_req = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (if_ack !== 1'b0 || d_ack !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_quiet%0d: if_ack=%b d_ack=%b busy=%b req=%b, want 0 0 0 0",
                         k, if_ack, d_ack, busy, mem_req);
            end
        end
        cur_wait = 1;
        dev_mem[8'h30] = 16'hC0DE;
        if_req = 1'b1;
        tick();
        tick();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0030 || grant !== 2'b01 || if_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_retry: req=%b addr=%h grant=%b ack=%b, want 1 0030 01 0",
                     mem_req, mem_addr, grant, if_ack);
        end
        tick();
        n_checks++;
        if (if_ack !== 1'b1 || if_rdata !== 16'hC0DE) begin
            n_fail++;
            $display("FAIL rst_mid_ack: ack=%b rdata=%h, want 1 c0de", if_ack, if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        cur_wait = -1;
        if_addr  = 16'h0040;
        if_req   = 1'b1;
        tick();
`ifdef MEM_TIMEOUT_EN
        for (int k = 0; k < int'(TO_CYC); k++) begin
            n_checks++;
            if (mem_req !== 1'b1 || bus_err !== 1'b0 || if_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL to_wait%0d: req=%b err=%b ack=%b, want 1 0 0", k, mem_req, bus_err, if_ack);
            end
            tick();
        end
        n_checks++;
        if (mem_req !== 1'b0 || if_ack !== 1'b1 || bus_err !== 1'b1 || if_rdata !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL to_abort: req=%b ack=%b err=%b rdata=%h, want 0 1 1 ffff",
                     mem_req, if_ack, bus_err, if_rdata);
        end
        if_req = 1'b0;
        tick();
        n_checks++;
        if (bus_err !== 1'b0 || if_ack !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_idle: err=%b ack=%b busy=%b, want 0 0 0", bus_err, if_ack, busy);
        end
        // Ack on the limit cycle completes normally.
        cur_wait = int'(TO_CYC) - 1;
        dev_mem[8'h41] = 16'h1357;
        if_addr = 16'h0041;
        if_req  = 1'b1;
        repeat (TO_CYC + 1) tick();
        n_checks++;
        if (if_ack !== 1'b1 || bus_err !== 1'b0 || if_rdata !== 16'h1357) begin
            n_fail++;
            $display("FAIL to_race: ack=%b err=%b rdata=%h, want 1 0 1357", if_ack, bus_err, if_rdata);
        end
        if_req = 1'b0;
        tick();
`else
        for (int k = 0; k < 1000; k++) begin
            n_checks++;
            if (busy !== 1'b1 || bus_err !== 1'b0 || mem_req !== 1'b1 || if_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL no_to%0d: busy=%b err=%b req=%b ack=%b, want 1 0 1 0",
                         k, busy, bus_err, mem_req, if_ack);
            end
            tick();
        end
        if_req = 1'b0;
        reset  = 1'b0;
        tick();
        reset = 1'b1;
        tick();
`endif
    endtask

    task automatic test_random();
        logic [DW-1:0] ref_mem [256];
        bit            active, own_d, ack_now;
        bit            x_we, s_if, s_d, s_dwe;
        int            t, w;
        logic [AW-1:0] x_addr, s_ia, s_da;
        logic [DW-1:0] x_wd, s_dwd, e_if, e_d;
        logic [1:0]    exp_grant;
        bit            exp_req, exp_if_ack, exp_d_ack;

        for (int i = 0; i < 256; i++) ref_mem[i] = dev_mem[i];
        if_req = 1'b0;
        d_req  = 1'b0;
        reset  = 1'b0;
        tick();
        reset    = 1'b1;
        noise_en = 1;
        cur_wait = $urandom_range(0, 3);
        active = 0; own_d = 0; t = 0; w = 0;
        x_we = 0; x_addr = '0; x_wd = '0;
        e_if = '0; e_d = '0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            s_if = if_req; s_ia = if_addr;
            s_d = d_req; s_dwe = d_we; s_da = d_addr; s_dwd = d_wdata;
            tick();

            // Transaction model: grant in idle, ACCESS lasts wait+1 cycles, then one ack cycle.
            if (!active) begin
                if (s_d) begin
                    active = 1; own_d = 1; t = 0; w = cur_wait;
                    x_we = s_dwe; x_addr = s_da; x_wd = s_dwd;
                end else if (s_if) begin
                    active = 1; own_d = 0; t = 0; w = cur_wait;
                    x_we = 0; x_addr = s_ia;
                end
            end else begin
                t++;
                if (t == w + 2) active = 0;
            end

            exp_grant  = !active ? 2'b00 : (own_d ? 2'b10 : 2'b01);
            exp_req    = active && (t <= w);
            ack_now    = active && (t == w + 1);
            exp_if_ack = ack_now && !own_d;
            exp_d_ack  = ack_now && own_d;
            if (ack_now) begin
                if (x_we) ref_mem[x_addr[7:0]] = x_wd;
                else if (own_d) e_d = ref_mem[x_addr[7:0]];
                else e_if = ref_mem[x_addr[7:0]];
            end

            n_checks++;
            if (busy !== active || grant !== exp_grant || mem_req !== exp_req || if_ack !== exp_if_ack ||
                d_ack !== exp_d_ack || bus_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc=%0d: busy=%b grant=%b req=%b if_ack=%b d_ack=%b err=%b, want %b %b %b %b %b 0",
                         cyc, busy, grant, mem_req, if_ack, d_ack, bus_err,
                         active, exp_grant, exp_req, exp_if_ack, exp_d_ack);
            end
            n_checks++;
            if (if_rdata !== e_if || d_rdata !== e_d) begin
                n_fail++;
                $display("FAIL rand_rdata cyc=%0d: if_rdata=%h d_rdata=%h, want %h %h",
                         cyc, if_rdata, d_rdata, e_if, e_d);
            end
            if (exp_req) begin
                n_checks++;
                if (mem_addr !== x_addr || mem_we !== x_we || (x_we && mem_wdata !== x_wd)) begin
                    n_fail++;
                    $display("FAIL rand_bus cyc=%0d: addr=%h we=%b wdata=%h, want %h %b %h",
                             cyc, mem_addr, mem_we, mem_wdata, x_addr, x_we, x_wd);
                end
            end

            if (!active) cur_wait = $urandom_range(0, 3);

            // Requesters hold until acked, then either re-request or drop.
            if (exp_d_ack || (!d_req && $urandom_range(0, 2) == 0)) begin
                d_req   = exp_d_ack ? 1'($urandom_range(0, 1)) : 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = AW'($urandom_range(0, 31));
                d_wdata = DW'($urandom);
            end
            if (exp_if_ack || (!if_req && $urandom_range(0, 2) == 0)) begin
                if_req  = exp_if_ack ? 1'($urandom_range(0, 1)) : 1'b1;
                if_addr = AW'($urandom_range(0, 31));
            end
        end
        noise_en = 0;
        if_req   = 1'b0;
        d_req    = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dev_mem[i] = DW'($urandom);
        #3;
        test_reset();
        test_zero_wait_fetch();
        test_contention();
        test_wait_states();
        test_reset_mid_access();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
